// File: rtl/relu_pkg.sv
// Shared definitions for the round-robin ReLU scheduler: requester-ID width
// helper, an all-zero word constant and the statistics counter width.
package relu_pkg;

  localparam int STAT_W    = 32;
  localparam int MAX_WIDTH = 256;

  // All-zero word; users slice the low WIDTH bits they need.
  localparam logic [MAX_WIDTH-1:0] ZERO_WORD = '0;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_rr_arbiter.sv
// Round-robin arbiter: scans req_valid starting at the pointer, wrapping
// modulo NUM_REQ, and picks the first valid requester. The one-hot grant is
// only asserted when the output stage can load.
module relu_rr_arbiter
  import relu_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]    i_pointer,
  input  logic               i_load,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_index,
  output logic               o_any_valid
);

  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  // Scan from the pointer, wrapping, and keep the first valid requester.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    o_grant     = '0;
    o_index     = '0;
    o_any_valid = 1'b0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, i_pointer} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(NUM_REQ);
      end
      w_cand = w_sum[ID_W-1:0];
      if (!o_any_valid && i_req_valid[w_cand]) begin
        o_any_valid = 1'b1;
        o_index     = w_cand;
      end
    end
    if (i_load && o_any_valid) begin
      o_grant[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/relu_width_parameterized.sv
// Combinational ReLU on a sign-magnitude word: any word with the sign bit
// set (including -0.0 and negative NaN) becomes all-zeros, everything else
// passes unchanged.
module relu_width_parameterized #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_clamped
);

  assign o_clamped = i_data[WIDTH-1];
  assign o_data    = o_clamped ? '0 : i_data;

endmodule

// File: rtl/relu_rr_scheduler.sv
// Shares one ReLU datapath between NUM_REQ valid/ready requesters using
// round-robin arbitration; results leave through a single registered stage
// tagged with the source requester index.
// Optional: define RELU_STATS_EN to add saturating transfer counters
// (stat_total, stat_clamped).
module relu_rr_scheduler
  import relu_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_clamped
`ifdef RELU_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_total,
  output logic [STAT_W-1:0]        stat_clamped
`endif
);

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [ID_W-1:0]    r_out_id;
  logic               r_out_clamped;
  logic [ID_W-1:0]    r_pointer;

  logic               w_load;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_index;
  logic               w_any_valid;
  logic [ID_W-1:0]    w_next_ptr;
  logic [WIDTH-1:0]   w_mux_word;
  logic [WIDTH-1:0]   w_relu_data;
  logic               w_relu_clamped;

  // The output register can take a new word when empty or being drained;
  // nothing is accepted while reset is held.
  assign w_load     = (!r_out_valid || out_ready) && !rst;
  assign w_accept   = w_load && w_any_valid;
  assign w_next_ptr = (w_index == ID_W'(NUM_REQ-1)) ? '0 : w_index + ID_W'(1);

  relu_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arbiter (
    .i_req_valid (req_valid),
    .i_pointer   (r_pointer),
    .i_load      (w_load),
    .o_grant     (w_grant),
    .o_index     (w_index),
    .o_any_valid (w_any_valid)
  );

  // Select the granted requester's word for the shared ReLU.
  always_comb begin
    w_mux_word = ZERO_WORD[WIDTH-1:0];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_index == ID_W'(i)) begin
        w_mux_word = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  relu_width_parameterized #(
    .WIDTH (WIDTH)
  ) u_relu (
    .i_data    (w_mux_word),
    .o_data    (w_relu_data),
    .o_clamped (w_relu_clamped)
  );

  // Output stage and round-robin pointer; holds while stalled.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= ZERO_WORD[WIDTH-1:0];
      r_out_id      <= '0;
      r_out_clamped <= 1'b0;
      r_pointer     <= '0;
    end else if (w_load) begin
      if (w_any_valid) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_relu_data;
        r_out_id      <= w_index;
        r_out_clamped <= w_relu_clamped;
        r_pointer     <= w_next_ptr;
      end else begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign req_ready   = w_grant;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_id      = r_out_id;
  assign out_clamped = r_out_clamped;

`ifdef RELU_STATS_EN
  logic [STAT_W-1:0] r_stat_total;
  logic [STAT_W-1:0] r_stat_clamped;

  // Saturating counters of accepted and clamped transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_total   <= '0;
      r_stat_clamped <= '0;
    end else if (w_accept) begin
      if (r_stat_total != '1) begin
        r_stat_total <= r_stat_total + STAT_W'(1);
      end
      if (w_relu_clamped && (r_stat_clamped != '1)) begin
        r_stat_clamped <= r_stat_clamped + STAT_W'(1);
      end
    end
  end

  assign stat_total   = r_stat_total;
  assign stat_clamped = r_stat_clamped;
`else
  // Statistics disabled: the accept strobe has no further consumer.
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_relu_rr_scheduler.sv
// Self-checking bench for relu_rr_scheduler (WIDTH=64, NUM_REQ=4): directed
// steps from the test plan followed by a randomized phase, all compared
// against a transaction-level reference model kept in the bench.
module tb_relu_rr_scheduler;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk       = 1'b0;
  logic           rst       = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data  = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_clamped;
`ifdef RELU_STATS_EN
  logic [31:0]    stat_total;
  logic [31:0]    stat_clamped;
`endif

  relu_rr_scheduler #(
    .WIDTH   (W),
    .NUM_REQ (N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
`ifdef RELU_STATS_EN
    .stat_total  (stat_total),
    .stat_clamped(stat_clamped),
`endif
    .out_clamped (out_clamped)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: next requester to favour, contents of the output slot,
  // and transfer counts since the last reset.
  int           m_ptr;
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id;
  bit           m_clamped;
  int           m_total;
  int           m_nclamp;
  logic [W-1:0] words [N];

  function automatic logic [W-1:0] ref_relu(input logic [W-1:0] x);
    if (x[W-1]) return '0;
    return x;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_id      = 0;
    m_clamped = 1'b0;
    m_total   = 0;
    m_nclamp  = 0;
  endtask

  // Hold reset with every requester valid; nothing may be accepted.
  task automatic do_reset(input int cycles);
    rst       = 1'b1;
    req_valid = '1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'(0));
      if (c > 0) check("rst_out_valid", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    req_valid = '0;
    model_reset();
    check("rst_out_valid_end", 64'(out_valid), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst_out_clamped", 64'(out_clamped), 64'(0));
`ifdef RELU_STATS_EN
    check("rst_stat_total", 64'(stat_total), 64'(0));
    check("rst_stat_clamped", 64'(stat_clamped), 64'(0));
`endif
  endtask

  // One clock: drive inputs, compare against the model mid-cycle, then
  // advance the model across the edge. Returns the model's grant (-1 if none)
  // and the ready vector the DUT showed.
  task automatic drive_cycle(input logic [N-1:0] v, input bit ordy,
                             output int g, output logic [N-1:0] rdy);
    bit           load;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = words[i];
    @(negedge clk);
    load    = !m_valid || ordy;
    g       = -1;
    exp_rdy = '0;
    if (load) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[IDW'(idx)]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[IDW'(g)] = 1'b1;
    rdy = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data", out_data, m_data);
    check("out_id", 64'(out_id), 64'(m_id));
    check("out_clamped", 64'(out_clamped), 64'(m_clamped));
    @(posedge clk);
    #1;
    if (load) begin
      if (g >= 0) begin
        m_valid   = 1'b1;
        m_data    = ref_relu(words[IDW'(g)]);
        m_id      = g;
        m_clamped = words[IDW'(g)][W-1];
        m_ptr     = (g + 1) % N;
        m_total++;
        if (m_clamped) m_nclamp++;
      end else begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           g;
    logic [N-1:0] rdy;
    logic [W-1:0] hold_data;
    logic [N-1:0] pend;
    int           wait_cnt [N];
    bit           ordy;
    int           dut_g;

    for (int i = 0; i < N; i++) words[i] = '0;
    model_reset();

    // Reset with all requesters valid, then first grant goes to 0.
    do_reset(3);
    words[0] = 64'h3FF0000000000000;
    drive_cycle(4'b1111, 1'b1, g, rdy);
    check("first_grant", 64'(rdy), 64'(4'b0001));
    drive_cycle(4'b0000, 1'b1, g, rdy);

    // Single requester, back-to-back, latency 1.
    do_reset(2);
    words[2] = $realtobits(1.5);
    drive_cycle(4'b0100, 1'b1, g, rdy);
    check("sr0_valid", 64'(out_valid), 64'(1));
    check("sr0_data", out_data, $realtobits(1.5));
    check("sr0_id", 64'(out_id), 64'(2));
    check("sr0_clamped", 64'(out_clamped), 64'(0));
    words[2] = $realtobits(-0.25);
    drive_cycle(4'b0100, 1'b1, g, rdy);
    check("sr1_data", out_data, 64'(0));
    check("sr1_clamped", 64'(out_clamped), 64'(1));
    words[2] = $realtobits(0.0);
    drive_cycle(4'b0100, 1'b1, g, rdy);
    check("sr2_data", out_data, 64'(0));
    check("sr2_id", 64'(out_id), 64'(2));
    check("sr2_clamped", 64'(out_clamped), 64'(0));
    drive_cycle(4'b0000, 1'b1, g, rdy);

    // Round-robin over all four, then the skip pattern.
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      for (int r = 0; r < N; r++) words[r] = {$urandom, $urandom};
      drive_cycle(4'b1111, 1'b1, g, rdy);
      check("rr_all_id", 64'(out_id), 64'(i % 4));
    end
    for (int i = 0; i < 4; i++) begin
      drive_cycle(4'b1010, 1'b1, g, rdy);
      check("rr_skip_id", 64'(out_id), 64'((i % 2 == 0) ? 1 : 3));
    end

    // Backpressure: five stalled cycles, then accept with no bubble.
    words[0] = 64'h4000000000000000;
    drive_cycle(4'b0001, 1'b1, g, rdy);
    hold_data = out_data;
    check("bp_loaded", hold_data, 64'h4000000000000000);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(4'b1111, 1'b0, g, rdy);
      check("bp_ready_zero", 64'(rdy), 64'(0));
      check("bp_data_hold", out_data, 64'h4000000000000000);
      check("bp_id_hold", 64'(out_id), 64'(0));
    end
    drive_cycle(4'b1111, 1'b1, g, rdy);
    check("bp_no_bubble", 64'(rdy), 64'(4'b0010));
    check("bp_next_id", 64'(out_id), 64'(1));

    // Special encodings.
    words[0] = 64'h8000000000000000;
    drive_cycle(4'b0001, 1'b1, g, rdy);
    check("neg_zero_data", out_data, 64'(0));
    check("neg_zero_clamped", 64'(out_clamped), 64'(1));
    words[0] = 64'hFFF8000000000000;
    drive_cycle(4'b0001, 1'b1, g, rdy);
    check("neg_nan_data", out_data, 64'(0));
    check("neg_nan_clamped", 64'(out_clamped), 64'(1));
    words[0] = 64'h7FF0000000000000;
    drive_cycle(4'b0001, 1'b1, g, rdy);
    check("pos_inf_data", out_data, 64'h7FF0000000000000);
    check("pos_inf_clamped", 64'(out_clamped), 64'(0));

    // Reset while a result is still in the output slot.
    check("mid_rst_pre_valid", 64'(out_valid), 64'(1));
    do_reset(2);

    // Randomized traffic: requesters hold until accepted; fairness bound.
    pend = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]     = 1'b1;
          words[i]    = {$urandom, $urandom};
          wait_cnt[i] = 0;
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      drive_cycle(pend, ordy, g, rdy);
      dut_g = -1;
      for (int i = 0; i < N; i++) if (rdy[i] && pend[i]) dut_g = i;
      if (dut_g >= 0) begin
        check("fairness", 64'(wait_cnt[dut_g] < N), 64'(1));
        for (int i = 0; i < N; i++) if (pend[i] && i != dut_g) wait_cnt[i]++;
        pend[dut_g] = 1'b0;
      end
    end
    drive_cycle(4'b0000, 1'b1, g, rdy);

`ifdef RELU_STATS_EN
    check("rand_stat_total", 64'(stat_total), 64'(m_total));
    check("rand_stat_clamped", 64'(stat_clamped), 64'(m_nclamp));
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      words[0] = {$urandom, $urandom};
      words[0][W-1] = (i == 1 || i == 4 || i == 6 || i == 9);
      drive_cycle(4'b0001, 1'b1, g, rdy);
    end
    drive_cycle(4'b0000, 1'b1, g, rdy);
    check("stat_total_10", 64'(stat_total), 64'(10));
    check("stat_clamped_4", 64'(stat_clamped), 64'(4));
    do_reset(2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_rr_scheduler.md
Name: relu_rr_scheduler

Overview:
- Shares one combinational ReLU datapath (relu_width_parameterized) between NUM_REQ requesters with round-robin arbitration.
- Each requester presents IEEE-754 words over valid/ready. Results leave through one registered output stage tagged with the source ID.
- Sits between per-lane producers (e.g. neuron accumulators) and the downstream activation consumer.

Parameters:
- WIDTH, 64, data word width in bits; bit WIDTH-1 is the sign bit.
- NUM_REQ, 4, number of requesters; must be 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_data  input  NUM_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_data  output  WIDTH  ReLU result.
- out_id  output  ID_W  source requester index; ID_W = clog2(NUM_REQ).
- out_clamped  output  1  result was forced to zero.

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high; it is sampled only at the clk edge.
- Reset values: out_valid=0, out_data=0, out_id=0, out_clamped=0, round-robin pointer=0, so requester 0 has top priority after reset.
- Load condition: load = !out_valid || out_ready. Output register is a one-entry pipeline stage and supports full throughput of 1 word/cycle.
- Arbitration is combinational on req_valid. Search starts at the pointer and wraps modulo NUM_REQ; the first valid requester g is granted.
- req_ready[g] = load; all other req_ready bits are 0. With no valid requests, req_ready is all zero.
- req_ready is a function of req_valid, the pointer and load. This is permitted; requesters must not make req_valid depend on req_ready.
- Transfer: when req_valid[g] && req_ready[g], on the next edge:
  - out_data = ReLU(req_data[g]), out_id = g, out_clamped = sign bit, out_valid = 1.
  - pointer = (g+1) mod NUM_REQ.
- If load and no request is valid: out_valid goes to 0 on the next edge; the pointer and data registers hold.
- Stall: out_valid && !out_ready holds out_data, out_id and out_clamped stable, and drives req_ready to all zero.
- Latency: exactly 1 cycle from accepted transfer to out_valid.
- ReLU rule: sign bit set → output all-zeros (+0.0). Otherwise the input passes unchanged. Consequences:
  - -0.0 → +0.0 with out_clamped=1.
  - Negative NaN → +0.0; positive NaN and +inf pass through.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted transfers.
- Reset mid-operation: an in-flight output is discarded (out_valid=0). A pending request is not accepted in the reset cycle; req_ready is all zero while rst=1.
- Upstream request hold: requesters must hold req_valid and req_data until accepted. The block does not check this.

Optional Feature:
- Macro: RELU_STATS_EN.
- With the macro defined, the block adds two outputs:
  - stat_total, 32 bits: count of accepted transfers.
  - stat_clamped, 32 bits: count of clamped transfers.
- Both counters increment on an accepted request transfer, saturate at 2^32-1, and clear on rst.
- With the macro undefined, these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package relu_pkg holds:
  - clog2-based ID width function.
  - ZERO_WORD constant.
  - STAT_W=32.
- Sub-module relu_rr_arbiter (NUM_REQ): inputs req_valid, pointer, load; outputs one-hot grant, encoded index and any_valid. Instantiated once.
- The datapath instantiates the existing relu_width_parameterized on the muxed word. It adds no new ReLU logic.

Test Plan:
- Reset: hold rst 3 cycles with all req_valid=1 → req_ready=0, out_valid=0 throughout. First grant after release goes to requester 0.
- Single requester: req 2 sends $realtobits(1.5), $realtobits(-0.25), $realtobits(0.0) back-to-back with out_ready=1. Required outputs, one per cycle with latency 1, all out_id=2:
  - 1.5, out_clamped=0.
  - 0.0, out_clamped=1.
  - 0.0, out_clamped=0.
- Round-robin: all 4 requesters continuously valid for 8 transfers → out_id sequence 0,1,2,3,0,1,2,3. Skip case: only req 1 and req 3 valid → sequence 1,3,1,3.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 → out_data, out_id and out_clamped stable, req_ready=0. On out_ready=1, a new word is accepted in that same cycle (no bubble).
- Special values: -0.0 (0x8000000000000000) → 0 with out_clamped=1. 0xFFF8000000000000 (negative NaN) → 0. 0x7FF0000000000000 (+inf) → unchanged.
- RELU_STATS_EN: 10 transfers, 4 of them negative → stat_total=10, stat_clamped=4. After rst both read 0.
